// File: rtl/full_adder.sv
// One-bit full adder: combinational sum/carry for the ripple chain, plus a registered
// copy of the result and a saturating count of edges at which carry-out was high.
module full_adder #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             c_in,
    output logic             s,
    output logic             c_out,
    output logic             s_q,
    output logic             c_out_q,
    output logic [CNT_W-1:0] carry_cnt
);

    logic             s_d;
    logic             c_out_d;
    logic [CNT_W-1:0] carry_cnt_d;
    logic [CNT_W-1:0] carry_cnt_q;

    // Carry-chain path: kept free of clk/rst so it stays valid during reset.
    always_comb begin
        s     = a ^ b ^ c_in;
        c_out = (a & b) | (a & c_in) | (b & c_in);
    end

    always_comb begin
        s_d         = s;
        c_out_d     = c_out;
        carry_cnt_d = carry_cnt_q;
        if (c_out && (carry_cnt_q != {CNT_W{1'b1}})) begin
            carry_cnt_d = carry_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q         <= 1'b0;
            c_out_q     <= 1'b0;
            carry_cnt_q <= '0;
        end else begin
            s_q         <= s_d;
            c_out_q     <= c_out_d;
            carry_cnt_q <= carry_cnt_d;
        end
    end

    assign carry_cnt = carry_cnt_q;

endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder: a default-width instance and a 2-bit counter
// instance share stimulus; the narrow one exercises counter saturation.
module tb_full_adder;

    logic       clk;
    logic       clk_en;
    logic       rst;
    logic       a;
    logic       b;
    logic       c_in;
    logic       s;
    logic       c_out;
    logic       s_q;
    logic       c_out_q;
    logic [7:0] carry_cnt;
    logic       s2;
    logic       c_out2;
    logic       s_q2;
    logic       c_out_q2;
    logic [1:0] carry_cnt2;

    int errors;
    int checks;

    full_adder #(.CNT_W(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .s         (s),
        .c_out     (c_out),
        .s_q       (s_q),
        .c_out_q   (c_out_q),
        .carry_cnt (carry_cnt)
    );

    full_adder #(.CNT_W(2)) u_dut_sat (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .s         (s2),
        .c_out     (c_out2),
        .s_q       (s_q2),
        .c_out_q   (c_out_q2),
        .carry_cnt (carry_cnt2)
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({s_q, c_out_q, carry_cnt} !== 10'd0) begin
            errors++;
            $display("FAIL reset_regs: got s_q=%b c_out_q=%b cnt=%0d, want 0 0 0",
                     s_q, c_out_q, carry_cnt);
        end
        checks++;
        if ({s_q2, c_out_q2, carry_cnt2} !== 4'd0) begin
            errors++;
            $display("FAIL reset_regs_sat: got s_q=%b c_out_q=%b cnt=%0d, want 0 0 0",
                     s_q2, c_out_q2, carry_cnt2);
        end
    endtask

    task automatic test_comb();
        logic [1:0] exp_tab [8];
        logic [2:0] v;
        exp_tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            {a, b, c_in} = v;
            #10;
            checks++;
            if ({c_out, s} !== exp_tab[i]) begin
                errors++;
                $display("FAIL comb_%b: got c_out,s=%b%b, want %b", v, c_out, s, exp_tab[i]);
            end
        end
    endtask

    task automatic test_latency();
        rst    = 1'b0;
        clk_en = 1'b1;
        {a, b, c_in} = 3'b110;
        #2;
        checks++;
        if ({s_q, c_out_q} !== 2'b00) begin
            errors++;
            $display("FAIL latency_pre: got s_q,c_out_q=%b%b, want 00", s_q, c_out_q);
        end
        tick();
        checks++;
        if ({s_q, c_out_q} !== 2'b01) begin
            errors++;
            $display("FAIL latency_post: got s_q,c_out_q=%b%b, want 01", s_q, c_out_q);
        end
    endtask

    task automatic test_carry_count();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        {a, b, c_in} = 3'b110;
        repeat (3) tick();
        {a, b, c_in} = 3'b000;
        repeat (2) tick();
        checks++;
        if (carry_cnt !== 8'd3) begin
            errors++;
            $display("FAIL carry_count: got %0d, want 3", carry_cnt);
        end
        checks++;
        if ({s_q, c_out_q} !== 2'b00) begin
            errors++;
            $display("FAIL carry_count_regs: got s_q,c_out_q=%b%b, want 00", s_q, c_out_q);
        end
        {a, b, c_in} = 3'b111;
        repeat (2) tick();
        checks++;
        if ({carry_cnt, s_q, c_out_q} !== {8'd5, 2'b11}) begin
            errors++;
            $display("FAIL carry_count_5: got cnt=%0d s_q=%b c_out_q=%b, want 5 1 1",
                     carry_cnt, s_q, c_out_q);
        end
    endtask

    task automatic test_async_reset();
        // Land between edges: currently 1 unit after a rising edge.
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({s_q, c_out_q, carry_cnt} !== 10'd0) begin
            errors++;
            $display("FAIL async_reset: got s_q=%b c_out_q=%b cnt=%0d, want 0 0 0",
                     s_q, c_out_q, carry_cnt);
        end
        {a, b, c_in} = 3'b101;
        #1;
        checks++;
        if ({c_out, s} !== 2'b10) begin
            errors++;
            $display("FAIL comb_in_reset: got c_out,s=%b%b, want 10", c_out, s);
        end
        tick();
        checks++;
        if ({s_q, c_out_q, carry_cnt} !== 10'd0) begin
            errors++;
            $display("FAIL reset_hold: got s_q=%b c_out_q=%b cnt=%0d, want 0 0 0",
                     s_q, c_out_q, carry_cnt);
        end
    endtask

    task automatic test_reset_release();
        {a, b, c_in} = 3'b101;
        rst = 1'b0;
        #1;
        checks++;
        if ({s_q, c_out_q, carry_cnt} !== 10'd0) begin
            errors++;
            $display("FAIL release_pre: got s_q=%b c_out_q=%b cnt=%0d, want 0 0 0",
                     s_q, c_out_q, carry_cnt);
        end
        tick();
        checks++;
        if ({s_q, c_out_q, carry_cnt} !== {2'b01, 8'd1}) begin
            errors++;
            $display("FAIL release_post: got s_q=%b c_out_q=%b cnt=%0d, want 0 1 1",
                     s_q, c_out_q, carry_cnt);
        end
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        {a, b, c_in} = 3'b111;
        repeat (3) tick();
        checks++;
        if (carry_cnt2 !== 2'd3) begin
            errors++;
            $display("FAIL sat_reach: got %0d, want 3", carry_cnt2);
        end
        repeat (3) tick();
        checks++;
        if ({carry_cnt2, s_q2, c_out_q2} !== 4'b1111) begin
            errors++;
            $display("FAIL sat_hold: got cnt=%0d s_q=%b c_out_q=%b, want 3 1 1",
                     carry_cnt2, s_q2, c_out_q2);
        end
        checks++;
        if (carry_cnt !== 8'd6) begin
            errors++;
            $display("FAIL sat_wide_cnt: got %0d, want 6", carry_cnt);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        clk    = 1'b0;
        clk_en = 1'b0;
        rst    = 1'b0;
        a      = 1'b0;
        b      = 1'b0;
        c_in   = 1'b0;
        test_reset();
        test_comb();
        test_latency();
        test_carry_count();
        test_async_reset();
        test_reset_release();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
